// File: rtl/smart_fans.sv
// Temperature-controlled 4-wire fan controller: UART command receiver, 25 kHz PWM,
// tachometer speed measurement and a once-per-second UART status report.
module smart_fans (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] temp_data,
    input  logic       rx,
    input  logic       fg_signal,
    output logic       pwm_out,
    output logic       tx
);

    localparam int CLK_HZ     = 50_000_000;
    localparam int BAUD_DIV   = 434;
    localparam int BAUD_MID   = 217;
    localparam int PWM_PERIOD = 2000;
    localparam int SEC_CNT    = CLK_HZ;
    localparam int EDGE_SAT   = 2185;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic        r_rx_busy;
    logic [8:0]  r_rx_baud;
    logic [3:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_low;
    logic        r_rx_ptr;
    logic [12:0] r_unpack_data;
    logic        w_rx_sample;

    logic [11:0] w_target;
    logic [11:0] w_half;
    logic [10:0] w_duty;
    logic [10:0] r_pwm_cnt;
    logic [10:0] r_duty_active;
    logic        r_pwm_out;

    logic        r_fg_s1, r_fg_s2, r_fg_prev;
    logic        w_fg_rise;
    logic [25:0] r_gate_cnt;
    logic [11:0] r_edge_cnt;
    logic [16:0] w_rpm_full;
    logic [15:0] r_rpm;

    state_t      r_state;
    logic [25:0] r_cnt_1s;
    logic [23:0] r_send_data;
    logic [4:0]  r_bit_cnt;
    logic [8:0]  r_baud_cnt;
    logic        r_send_flag;
    logic        r_bit_flag;
    logic        r_tx;
    logic [3:0]  w_pos;
    logic [2:0]  w_idx;
    logic [7:0]  w_byte;
    logic        w_tx_bit;

    assign w_rx_sample = r_rx_busy && (r_rx_baud == 9'(BAUD_MID));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_s1       <= 1'b1;
            r_rx_s2       <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_rx_busy     <= 1'b0;
            r_rx_baud     <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_rx_low      <= '0;
            r_rx_ptr      <= 1'b0;
            r_unpack_data <= '0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_s2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_baud <= '0;
                    r_rx_bit  <= '0;
                end
            end else begin
                if (r_rx_baud == 9'(BAUD_DIV - 1)) begin
                    r_rx_baud <= '0;
                    r_rx_bit  <= r_rx_bit + 4'd1;
                end else begin
                    r_rx_baud <= r_rx_baud + 9'd1;
                end
                if (w_rx_sample) begin
                    if (r_rx_bit >= 4'd1 && r_rx_bit <= 4'd8) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    end else if (r_rx_bit == 4'd9) begin
                        r_rx_busy <= 1'b0;
                        // A bad stop bit drops the byte and resynchronises pairing on the low byte
                        if (!r_rx_s2) begin
                            r_rx_ptr <= 1'b0;
                        end else if (!r_rx_ptr) begin
                            r_rx_low <= r_rx_shift;
                            r_rx_ptr <= 1'b1;
                        end else begin
                            r_unpack_data <= {r_rx_shift[4:0], r_rx_low};
                            r_rx_ptr      <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign w_target = r_unpack_data[11:0];
    assign w_half   = w_target >> 1;

    always_comb begin
        w_duty = '0;
        if (r_unpack_data[12]) begin
            w_duty = (w_half > 12'd2000) ? 11'd2000 : w_half[10:0];
        end else if (temp_data >= 8'd60) begin
            w_duty = 11'd2000;
        end else if (temp_data >= 8'd50) begin
            w_duty = 11'd1500;
        end else if (temp_data >= 8'd40) begin
            w_duty = 11'd1000;
        end else if (temp_data >= 8'd30) begin
            w_duty = 11'd500;
        end
    end

    // Duty is only reloaded on the last count so every period is whole
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pwm_cnt     <= '0;
            r_duty_active <= '0;
            r_pwm_out     <= 1'b0;
        end else begin
            if (r_pwm_cnt == 11'(PWM_PERIOD - 1)) begin
                r_pwm_cnt     <= '0;
                r_duty_active <= w_duty;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + 11'd1;
            end
            r_pwm_out <= (r_pwm_cnt < r_duty_active);
        end
    end

    assign w_fg_rise  = r_fg_s2 && !r_fg_prev;
    assign w_rpm_full = 17'(r_edge_cnt) * 17'd30;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_fg_s1    <= 1'b0;
            r_fg_s2    <= 1'b0;
            r_fg_prev  <= 1'b0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_rpm      <= '0;
        end else begin
            r_fg_s1   <= fg_signal;
            r_fg_s2   <= r_fg_s1;
            r_fg_prev <= r_fg_s2;
            if (r_gate_cnt == 26'(SEC_CNT - 1)) begin
                r_gate_cnt <= '0;
                r_rpm      <= (w_rpm_full > 17'd65535) ? 16'hFFFF : w_rpm_full[15:0];
                r_edge_cnt <= {11'd0, w_fg_rise};
            end else begin
                r_gate_cnt <= r_gate_cnt + 26'd1;
                // Holding at EDGE_SAT is enough to force the saturated RPM
                if (w_fg_rise && r_edge_cnt != 12'(EDGE_SAT)) begin
                    r_edge_cnt <= r_edge_cnt + 12'd1;
                end
            end
        end
    end

    always_comb begin
        w_pos  = r_bit_cnt[3:0];
        w_byte = r_send_data[23:16];
        if (r_bit_cnt >= 5'd20) begin
            w_pos  = 4'(r_bit_cnt - 5'd20);
            w_byte = r_send_data[7:0];
        end else if (r_bit_cnt >= 5'd10) begin
            w_pos  = 4'(r_bit_cnt - 5'd10);
            w_byte = r_send_data[15:8];
        end
        w_idx    = 3'(w_pos - 4'd1);
        w_tx_bit = 1'b1;
        if (w_pos == 4'd0) begin
            w_tx_bit = 1'b0;
        end else if (w_pos <= 4'd8) begin
            w_tx_bit = w_byte[w_idx];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt_1s    <= '0;
            r_send_data <= '0;
            r_bit_cnt   <= '0;
            r_baud_cnt  <= '0;
            r_send_flag <= 1'b0;
            r_bit_flag  <= 1'b0;
            r_tx        <= 1'b1;
        end else begin
            r_cnt_1s   <= (r_cnt_1s == 26'(SEC_CNT - 1)) ? 26'd0 : r_cnt_1s + 26'd1;
            r_bit_flag <= (r_state == S_SEND) && (r_baud_cnt == 9'(BAUD_DIV - 2));
            r_tx       <= r_send_flag ? w_tx_bit : 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_cnt_1s == 26'(SEC_CNT - 1)) begin
                        r_send_data <= {temp_data, r_rpm[15:8], r_rpm[7:0]};
                        r_bit_cnt   <= '0;
                        r_baud_cnt  <= '0;
                        r_send_flag <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_bit_flag) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == 5'd29) begin
                            r_send_flag <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 9'd1;
                    end
                end
                S_DONE: begin
                    r_bit_cnt <= '0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pwm_out = r_pwm_out;
    assign tx      = r_tx;

endmodule

// File: tb/tb_smart_fans.sv
// Scoreboard bench for smart_fans: random commands and temperatures against a spec-level model.
module tb_smart_fans;

    localparam int BAUD = 434;
    localparam int SEC  = 50_000_000;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] temp_data = 8'd0;
    logic       rx = 1'b1;
    logic       fg_signal = 1'b0;
    logic       pwm_out;
    logic       tx;

    int total = 0;
    int bad   = 0;

    int         q_pwm[$];
    int         q_rpm[$];
    logic [7:0] q_tx[$];

    logic [12:0] m_unpack = '0;
    logic        m_ptr = 1'b0;
    logic [7:0]  m_low = '0;
    int          m_rpm = 0;

    smart_fans dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .temp_data (temp_data),
        .rx        (rx),
        .fg_signal (fg_signal),
        .pwm_out   (pwm_out),
        .tx        (tx)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model_duty(input logic [12:0] u, input logic [7:0] t);
        int h;
        if (u[12]) begin
            h = int'(u[11:0]) / 2;
            return (h > 2000) ? 2000 : h;
        end
        if (t < 30) return 0;
        if (t < 40) return 500;
        if (t < 50) return 1000;
        if (t < 60) return 1500;
        return 2000;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        clks(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clks(BAUD);
        end
        rx = stop;
        clks(BAUD);
        rx = 1'b1;
        clks(20);
        if (!stop) begin
            m_ptr = 1'b0;
        end else if (!m_ptr) begin
            m_low = b;
            m_ptr = 1'b1;
        end else begin
            m_unpack = {b[4:0], m_low};
            m_ptr    = 1'b0;
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
        check("unpack_data", int'(dut.r_unpack_data), int'(m_unpack));
    endtask

    task automatic expect_pwm(input string name);
        q_pwm.push_back(model_duty(m_unpack, temp_data));
        for (int i = 0; i < 6000 && q_pwm.size() != 0; i++) @(negedge sys_clk);
        check({name, "_pending"}, q_pwm.size(), 0);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            fg_signal = 1'b1;
            clks(3);
            fg_signal = 1'b0;
            clks(3);
        end
    endtask

    task automatic gate_end(input int edges);
        m_rpm = (edges * 30 > 65535) ? 65535 : edges * 30;
        q_rpm.push_back(m_rpm);
        clks(6);
        force dut.r_gate_cnt = 26'(SEC - 4);
        clks(1);
        release dut.r_gate_cnt;
        for (int i = 0; i < 20 && q_rpm.size() != 0; i++) @(negedge sys_clk);
        check("rpm_pending", q_rpm.size(), 0);
    endtask

    // PWM monitor: after a settling period any 2000-clock window holds exactly one period
    initial begin
        forever begin
            @(negedge sys_clk);
            if (q_pwm.size() != 0) begin
                int hi;
                hi = 0;
                clks(2005);
                repeat (2000) begin
                    @(negedge sys_clk);
                    if (pwm_out) hi++;
                end
                check("pwm_high_clocks", hi, q_pwm.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && q_rpm.size() != 0 && dut.r_gate_cnt == 26'd0) begin
                check("rpm", int'(dut.r_rpm), q_rpm.pop_front());
            end
        end
    end

    // UART monitor on tx: decode each frame at bit centres
    initial begin
        logic prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (prev && !tx) begin
                clks(BAUD / 2);
                check("tx_start_bit", int'(tx), 0);
                for (int i = 0; i < 8; i++) begin
                    clks(BAUD);
                    b[i] = tx;
                end
                clks(BAUD);
                check("tx_stop_bit", int'(tx), 1);
                if (q_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected_byte actual=0x%02h required=none", b);
                end else begin
                    check("tx_byte", int'(b), int'(q_tx.pop_front()));
                end
            end
            prev = tx;
        end
    end

    initial begin
        int sf_cnt, bf_cnt, bit_max, n;
        logic [15:0] w;

        temp_data = 8'($urandom_range(0, 29));
        clks(5);
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_tx", int'(tx), 1);
        check("reset_rpm", int'(dut.r_rpm), 0);
        check("reset_unpack", int'(dut.r_unpack_data), 0);
        sys_rst_n = 1'b1;

        expect_pwm("auto_cold");

        send_word(16'h13E8);
        expect_pwm("manual_1000");
        send_word(16'h1ED8);
        expect_pwm("manual_3800");

        // Valid low byte then a framing error: the pending low byte must be forgotten
        send_byte(8'h55, 1'b1);
        send_byte(8'hA7, 1'b0);
        check("unpack_after_frame_err", int'(dut.r_unpack_data), int'(m_unpack));
        w = {3'($urandom), 1'b1, 12'($urandom)};
        send_word(w);
        expect_pwm("manual_random");

        temp_data = 8'd60;
        send_word(16'h0000);
        expect_pwm("auto_60");
        temp_data = 8'($urandom_range(30, 39));
        expect_pwm("auto_30s");
        temp_data = 8'd100;
        expect_pwm("auto_100");

        gate_end(0);
        pulses(100);
        gate_end(100);
        force dut.r_edge_cnt = 12'd2180;
        clks(1);
        release dut.r_edge_cnt;
        pulses(4);
        gate_end(2184);
        force dut.r_edge_cnt = 12'd2180;
        clks(1);
        release dut.r_edge_cnt;
        n = $urandom_range(5, 20);
        pulses(n);
        gate_end(2180 + n);
        pulses(32);
        gate_end(32);

        temp_data = 8'd60;
        q_tx.push_back(temp_data);
        q_tx.push_back(8'(m_rpm >> 8));
        q_tx.push_back(8'(m_rpm));
        sf_cnt = 0;
        bf_cnt = 0;
        bit_max = 0;
        force dut.r_cnt_1s = 26'(SEC - 3);
        clks(1);
        release dut.r_cnt_1s;
        repeat (13100) begin
            @(negedge sys_clk);
            if (dut.r_send_flag) sf_cnt++;
            if (dut.r_bit_flag) bf_cnt++;
            if (int'(dut.r_bit_cnt) > bit_max) bit_max = int'(dut.r_bit_cnt);
        end
        check("send_flag_clocks", sf_cnt, 13020);
        check("bit_flag_pulses", bf_cnt, 30);
        check("bit_cnt_max", bit_max, 29);
        for (int i = 0; i < 2000 && q_tx.size() != 0; i++) @(negedge sys_clk);
        check("tx_bytes_pending", q_tx.size(), 0);
        check("tx_idle_after", int'(tx), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
